wb_seq_master: RTL

Parametrised Wishbone pipelined-mode bus master that replays a fixed table of DEPTH transactions (write or read) to a slave such as the LED PWM peripheral. It generalises the hand-coded three-write bring-up sequencer: arbitrary entry count, widths, reads with captured data, stall and ack handling, `i_wb_err`, a bus timeout, optional looping and restart on demand. It sits at the top level between board reset and the first peripheral on the bus.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_seq_rom.sv | 33 +++
 rtl/wb_seq_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone sequence master: FSM states and
// the field layout of one {we, addr, data} table entry.
package wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_ACK,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned we_bit(input int unsigned addr_w, input int unsigned data_w);
    return data_w + addr_w;
  endfunction

  // Index width never drops below one bit, even for a single-entry table.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_seq_rom.sv
// Combinational lookup of one transaction entry from the packed INIT table.
module wb_seq_rom
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned IDX_W  = 2,
  parameter logic [DEPTH*(1+ADDR_W+DATA_W)-1:0] INIT = '0
) (
  input  logic [IDX_W-1:0]  idx,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;

  logic [ENT_W-1:0] entry;

  // Constant-slice mux keeps out-of-range indices (non power-of-two DEPTH) at zero.
  always_comb begin
    entry = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (idx == IDX_W'(k)) entry = INIT[k*ENT_W +: ENT_W];
    end
  end

  assign data = entry[DATA_LSB +: DATA_W];
  assign addr = entry[addr_lsb(DATA_W) +: ADDR_W];
  assign we   = entry[we_bit(ADDR_W, DATA_W)];

endmodule

// File: rtl/wb_seq_master.sv
// Wishbone pipelined master replaying a fixed table of write/read transactions,
// with stall/ack/err handling, per-entry timeout, optional looping and restart.
module wb_seq_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 3,
  parameter logic [DEPTH*(1+ADDR_W+DATA_W)-1:0] INIT = '0,
  parameter bit          LOOP      = 1'b0,
  parameter bit          AUTOSTART = 1'b1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        i_wb_clk,
  input  logic                        i_wb_rst,
  input  logic                        i_start,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [ADDR_W-1:0]           o_wb_addr,
  output logic [DATA_W-1:0]           o_wb_data,
  input  logic [DATA_W-1:0]           i_wb_data,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  output logic [DATA_W-1:0]           o_rd_data,
  output logic                        o_rd_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [idx_width(DEPTH)-1:0] o_err_idx
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               first;
  logic               capture;
  logic               e_we;
  logic [ADDR_W-1:0]  e_addr;
  logic [DATA_W-1:0]  e_data;

  wb_seq_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .INIT   (INIT)
  ) u_rom (
    .idx  (idx),
    .we   (e_we),
    .addr (e_addr),
    .data (e_data)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((AUTOSTART && first) || i_start) begin
          state_nx = ST_REQUEST;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      ST_REQUEST: begin
        cnt_nx = cnt + 1'b1;
        if (i_wb_err) begin
          state_nx = ST_ERROR;
        end else if (!i_wb_stall && i_wb_ack) begin
          state_nx = ST_NEXT;
          capture  = !e_we;
        end else if (cnt == TMO_LAST) begin
          state_nx = ST_ERROR;
        end else if (!i_wb_stall) begin
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        cnt_nx = cnt + 1'b1;
        if (i_wb_err) begin
          state_nx = ST_ERROR;
        end else if (i_wb_ack) begin
          state_nx = ST_NEXT;
          capture  = !e_we;
        end else if (cnt == TMO_LAST) begin
          state_nx = ST_ERROR;
        end
      end
      ST_NEXT: begin
        cnt_nx = '0;
        if (idx != IDX_LAST) begin
          idx_nx   = idx + 1'b1;
          state_nx = ST_REQUEST;
        end else if (LOOP) begin
          idx_nx   = '0;
          state_nx = ST_REQUEST;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_nx = ST_REQUEST;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      first      <= 1'b1;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_err_idx  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      first      <= 1'b0;
      o_rd_valid <= capture;
      if (capture) o_rd_data <= i_wb_data;
      if (state_nx == ST_ERROR && state != ST_ERROR) o_err_idx <= idx;
    end
  end

  // Bus outputs decode from registered state/index only; payload is zero outside a strobe.
  assign o_wb_cyc  = (state == ST_REQUEST) || (state == ST_WAIT_ACK);
  assign o_wb_stb  = (state == ST_REQUEST);
  assign o_wb_we   = o_wb_stb && e_we;
  assign o_wb_addr = o_wb_stb ? e_addr : '0;
  assign o_wb_data = o_wb_stb ? e_data : '0;
  assign o_busy    = o_wb_cyc;
  assign o_done    = (state == ST_DONE);
  assign o_error   = (state == ST_ERROR);

endmodule
